// File: rtl/ysyx_22040759_mem_stage.sv
// Memory pipeline stage: holds one instruction from EX, runs its load/store over a
// request/response data port, and hands the result to WB under valid/allowin handshakes.
module ysyx_22040759_mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         es_to_ms_valid,
    input  logic [236:0] es_to_ms_bus,
    output logic         ms_allowin,
    output logic         ms_to_ws_valid,
    output logic [231:0] ms_to_ws_bus,
    input  logic         ws_allowin,
    output logic         data_req_valid,
    input  logic         data_req_ready,
    output logic         data_req_wen,
    output logic [63:0]  data_req_addr,
    output logic [63:0]  data_req_wdata,
    output logic [7:0]   data_req_wmask,
    input  logic         data_resp_valid,
    input  logic [63:0]  data_resp_rdata
);

    // state  | meaning
    // S_IDLE | no memory op outstanding (stage empty or holding a non-memory op)
    // S_REQ  | request presented, waiting for data_req_ready
    // S_WAIT | request accepted, waiting for data_resp_valid
    // S_DONE | memory op finished, waiting for WB to take it
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           ms_valid_q, ms_valid_d;
    logic [236:0]   bus_q;
    logic [63:0]    rdata_q, rdata_d;

    logic           mem_ren, mem_wen, mem_uns, is_mem, new_is_mem;
    logic [1:0]     mem_size;
    logic [2:0]     byte_off;
    logic [63:0]    store_data, alu_result;
    logic           ms_ready_go, capture;
    logic [63:0]    resp_shifted, load_ext;
    logic [7:0]     size_mask;

    assign mem_ren    = bus_q[196];
    assign mem_wen    = bus_q[195];
    assign mem_size   = bus_q[194:193];
    assign mem_uns    = bus_q[192];
    assign store_data = bus_q[191:128];
    assign alu_result = bus_q[127:64];
    assign byte_off   = alu_result[2:0];
    assign is_mem     = mem_ren | mem_wen;
    assign new_is_mem = es_to_ms_bus[196] | es_to_ms_bus[195];

    assign ms_ready_go    = !is_mem || (state_q == S_DONE);
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign capture        = es_to_ms_valid && ms_allowin;
    assign ms_valid_d     = ms_allowin ? es_to_ms_valid : ms_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (capture && new_is_mem) state_d = S_REQ;
            S_REQ:  if (data_req_ready) state_d = S_WAIT;
            S_WAIT: if (data_resp_valid) state_d = S_DONE;
            S_DONE: if (ws_allowin) state_d = (capture && new_is_mem) ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields come straight from the held bus, so they cannot move during a stall.
    assign data_req_valid = (state_q == S_REQ);
    assign data_req_wen   = mem_wen;
    assign data_req_addr  = {alu_result[63:3], 3'b000};
    assign data_req_wdata = store_data << {byte_off, 3'b000};
    assign data_req_wmask = size_mask << byte_off;

    always_comb begin
        case (mem_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign resp_shifted = data_resp_rdata >> {byte_off, 3'b000};

    always_comb begin
        case (mem_size)
            2'd0:    load_ext = mem_uns ? {56'd0, resp_shifted[7:0]}
                                        : {{56{resp_shifted[7]}}, resp_shifted[7:0]};
            2'd1:    load_ext = mem_uns ? {48'd0, resp_shifted[15:0]}
                                        : {{48{resp_shifted[15]}}, resp_shifted[15:0]};
            2'd2:    load_ext = mem_uns ? {32'd0, resp_shifted[31:0]}
                                        : {{32{resp_shifted[31]}}, resp_shifted[31:0]};
            default: load_ext = resp_shifted;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (state_q == S_WAIT && data_resp_valid && mem_ren) rdata_d = load_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ms_valid_q <= 1'b0;
            rdata_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            ms_valid_q <= ms_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) bus_q <= es_to_ms_bus;
    end

    // Stores and non-memory ops always report zero read data.
    assign ms_to_ws_bus = {bus_q[236:197], (mem_ren ? rdata_q : 64'd0), bus_q[127:0]};

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Scoreboard bench for ysyx_22040759_mem_stage: directed scenarios followed by random
// traffic, with a memory responder and a WB monitor checking against a reference model.
module tb_ysyx_22040759_mem_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         es_to_ms_valid = 1'b0;
    logic [236:0] es_to_ms_bus = '0;
    logic         ms_allowin;
    logic         ms_to_ws_valid;
    logic [231:0] ms_to_ws_bus;
    logic         ws_allowin = 1'b1;
    logic         data_req_valid;
    logic         data_req_ready = 1'b0;
    logic         data_req_wen;
    logic [63:0]  data_req_addr;
    logic [63:0]  data_req_wdata;
    logic [7:0]   data_req_wmask;
    logic         data_resp_valid = 1'b0;
    logic [63:0]  data_resp_rdata = '0;

    ysyx_22040759_mem_stage dut (
        .clk(clk), .rst(rst),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_allowin(ms_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_wen(data_req_wen), .data_req_addr(data_req_addr),
        .data_req_wdata(data_req_wdata), .data_req_wmask(data_req_wmask),
        .data_resp_valid(data_resp_valid), .data_resp_rdata(data_resp_rdata)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [231:0] bus; int cap; bit is_mem; } exp_t;
    typedef struct { logic [63:0] addr; bit wen; logic [63:0] wdata; logic [7:0] wmask; } req_t;
    exp_t sb_q[$];
    req_t rq_q[$];

    // environment knobs
    int          bp_mode = 1;      // 0 random, 1 always accept, 2 never accept
    int          ready_mode = 1;   // 0 never ready, 1 always, 2 random
    int          rsp_max = 0;
    bit          rsp_hold = 0;
    bit          spur_en = 0;
    bit          inject_spur = 0;
    bit          force_en = 0;
    logic [63:0] force_val = '0;

    task automatic check(string name, logic [231:0] got, logic [231:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_fn(logic [63:0] a);
        return {a[31:0] ^ 32'h9E37_79B9, ~a[31:0] ^ {a[15:0], a[31:16]}};
    endfunction

    function automatic logic [63:0] load_model(logic [63:0] word, logic [2:0] off,
                                               logic [1:0] size, bit uns);
        int nbits;
        logic [63:0] v, mask;
        nbits = 8 << size;
        v     = word >> (8 * off);
        mask  = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
        v     = v & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] store_mask(logic [2:0] off, logic [1:0] size);
        logic [7:0] m;
        int nb;
        m  = '0;
        nb = 1 << size;
        for (int l = 0; l < 8; l++)
            if (l >= int'(off) && l < int'(off) + nb) m[l] = 1'b1;
        return m;
    endfunction

    function automatic logic [236:0] mk_in(logic [31:0] inst, logic rw, logic [4:0] rd,
            logic [1:0] sel, logic ren, logic wen, logic [1:0] sz, logic uns,
            logic [63:0] sd, logic [63:0] alu, logic [63:0] pc);
        return {inst, rw, rd, sel, ren, wen, sz, uns, sd, alu, pc};
    endfunction

    function automatic logic [231:0] mk_out(logic [31:0] inst, logic rw, logic [4:0] rd,
            logic [1:0] sel, logic [63:0] rdata, logic [63:0] alu, logic [63:0] pc);
        return {inst, rw, rd, sel, rdata, alu, pc};
    endfunction

    // Called at posedge+#1; leaves at posedge+#1 right after the capturing edge.
    task automatic issue(logic [236:0] b, logic [231:0] exp_out, bit has_req, req_t r);
        int n;
        exp_t e;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (ms_allowin) break;
            n++;
            if (n > 300) begin
                chk_cnt++; err_cnt++;
                $display("FAIL issue_timeout: allowin stuck 0 for %0d cycles, required 1", n);
                es_to_ms_valid = 1'b0;
                return;
            end
        end
        e.bus = exp_out; e.cap = cyc; e.is_mem = b[196] | b[195];
        sb_q.push_back(e);
        if (has_req) rq_q.push_back(r);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_empty(int lim);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || rq_q.size() != 0) && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", sb_q.size() + rq_q.size(), 0);
    endtask

    // WB side back-pressure
    initial forever begin
        @(posedge clk); #1;
        case (bp_mode)
            0:       ws_allowin = ($urandom_range(0, 3) != 0);
            1:       ws_allowin = 1'b1;
            default: ws_allowin = 1'b0;
        endcase
    end

    // Memory responder and request checker
    initial begin
        bit hs, pend, drv;
        int dly;
        logic [63:0] raddr;
        hs = 0; pend = 0; drv = 0; dly = 0; raddr = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                hs = 0; pend = 0; drv = 0;
                data_req_ready = 1'b0;
                data_resp_valid = 1'b0;
                continue;
            end
            if (drv) begin pend = 0; drv = 0; end
            if (hs) begin pend = 1; hs = 0; dly = $urandom_range(0, rsp_max); end
            data_resp_valid = 1'b0;
            data_resp_rdata = {$urandom, $urandom};
            if (pend) begin
                if (!rsp_hold) begin
                    if (dly == 0) begin
                        data_resp_valid = 1'b1;
                        data_resp_rdata = force_en ? force_val : mem_fn(raddr);
                        drv = 1;
                    end else dly--;
                end
            end else if (inject_spur || (spur_en && $urandom_range(0, 5) == 0)) begin
                data_resp_valid = 1'b1;
            end
            case (ready_mode)
                0:       data_req_ready = 1'b0;
                1:       data_req_ready = 1'b1;
                default: data_req_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (data_req_valid) begin
                if (rq_q.size() == 0) begin
                    chk_cnt++; err_cnt++;
                    $display("FAIL unexpected_req: data_req_valid 1 addr %h, required no request", data_req_addr);
                end else begin
                    check("req_addr", data_req_addr, rq_q[0].addr);
                    check("req_wen", data_req_wen, rq_q[0].wen);
                    if (rq_q[0].wen) begin
                        check("req_wmask", data_req_wmask, rq_q[0].wmask);
                        check("req_wdata", data_req_wdata, rq_q[0].wdata);
                    end
                    if (data_req_ready) begin
                        raddr = data_req_addr;
                        hs = 1;
                        void'(rq_q.pop_front());
                    end
                end
            end
        end
    end

    // WB monitor
    initial begin
        bit seen, prev_stall;
        logic [231:0] prev_bus;
        seen = 0; prev_stall = 0; prev_bus = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin seen = 0; prev_stall = 0; continue; end
            if (prev_stall) begin
                check("bp_valid_hold", ms_to_ws_valid, 1);
                check("bp_bus_hold", ms_to_ws_bus, prev_bus);
            end
            if (ms_to_ws_valid) begin
                if (sb_q.size() == 0) begin
                    chk_cnt++; err_cnt++;
                    $display("FAIL unexpected_wb: bus %h presented, required nothing", ms_to_ws_bus);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        if (sb_q[0].is_mem) check("mem_latency_ge3", (cyc - sb_q[0].cap) >= 3, 1);
                        else                check("alu_latency", cyc - sb_q[0].cap, 1);
                    end
                    if (ws_allowin) begin
                        check("wb_bus", ms_to_ws_bus, sb_q[0].bus);
                        void'(sb_q.pop_front());
                        seen = 0;
                    end
                end
            end
            prev_stall = ms_to_ws_valid && !ws_allowin;
            prev_bus   = ms_to_ws_bus;
        end
    end

    initial begin
        req_t r, none;
        logic [236:0] b;
        logic [231:0] o;
        logic [63:0] a, sd, pc, rdv;
        logic [31:0] inst;
        logic [4:0] rd;
        logic [1:0] sel, sz;
        logic rw, uns;
        int kind, n;

        none = '{addr: '0, wen: 0, wdata: '0, wmask: '0};

        repeat (3) @(posedge clk);
        #2;
        check("rst_allowin", ms_allowin, 1);
        check("rst_wb_valid", ms_to_ws_valid, 0);
        check("rst_req_valid", data_req_valid, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // non-memory op: one cycle through, rdata zero
        b = mk_in(32'h0000_0033, 1, 5'd7, 2'd0, 0, 0, 2'd3, 0, 64'hDEAD, 64'h1234, 64'h8000_0100);
        o = mk_out(32'h0000_0033, 1, 5'd7, 2'd0, 64'd0, 64'h1234, 64'h8000_0100);
        issue(b, o, 0, none);
        check("alu_valid_n1", ms_to_ws_valid, 1);
        check("alu_rdata_zero", ms_to_ws_bus[191:128], 64'd0);
        check("alu_result_pass", ms_to_ws_bus[127:64], 64'h1234);
        wait_empty(50);

        // lb / lbu with a fixed response word
        force_en = 1; force_val = 64'h0000_0000_8000_0000;
        r = '{addr: 64'h8000_0000, wen: 0, wdata: '0, wmask: '0};
        b = mk_in(32'h0031_8283, 1, 5'd5, 2'd1, 1, 0, 2'd0, 0, 64'd0, 64'h8000_0003, 64'h8000_0104);
        o = mk_out(32'h0031_8283, 1, 5'd5, 2'd1, 64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0003, 64'h8000_0104);
        issue(b, o, 1, r);
        wait_empty(50);
        b = mk_in(32'h0031_C283, 1, 5'd5, 2'd1, 1, 0, 2'd0, 1, 64'd0, 64'h8000_0003, 64'h8000_0108);
        o = mk_out(32'h0031_C283, 1, 5'd5, 2'd1, 64'h80, 64'h8000_0003, 64'h8000_0108);
        issue(b, o, 1, r);
        wait_empty(50);

        // sh to byte offset 6
        r = '{addr: 64'h8000_0000, wen: 1, wdata: 64'hBEEF_0000_0000_0000, wmask: 8'hC0};
        b = mk_in(32'h0051_1323, 0, 5'd0, 2'd0, 0, 1, 2'd1, 0, 64'hBEEF, 64'h8000_0006, 64'h8000_010C);
        o = mk_out(32'h0051_1323, 0, 5'd0, 2'd0, 64'd0, 64'h8000_0006, 64'h8000_010C);
        issue(b, o, 1, r);
        wait_empty(50);
        force_en = 0;

        // request stalled five cycles by data_req_ready
        ready_mode = 0;
        a = 64'h8000_2010;
        r = '{addr: a, wen: 0, wdata: '0, wmask: '0};
        b = mk_in(32'h0001_3403, 1, 5'd8, 2'd1, 1, 0, 2'd3, 0, 64'd0, a, 64'h8000_0110);
        o = mk_out(32'h0001_3403, 1, 5'd8, 2'd1, mem_fn(a), a, 64'h8000_0110);
        issue(b, o, 1, r);
        repeat (5) begin
            @(negedge clk);
            check("stall_allowin", ms_allowin, 0);
            check("stall_no_wb", ms_to_ws_valid, 0);
            check("stall_req_valid", data_req_valid, 1);
        end
        ready_mode = 1;
        wait_empty(50);

        // WB back-pressure in DONE, then a back-to-back ld on release
        bp_mode = 2;
        a = 64'h8000_3005;
        r = '{addr: 64'h8000_3000, wen: 0, wdata: '0, wmask: '0};
        b = mk_in(32'h0002_B483, 1, 5'd9, 2'd1, 1, 0, 2'd3, 0, 64'd0, a, 64'h8000_0114);
        o = mk_out(32'h0002_B483, 1, 5'd9, 2'd1, load_model(mem_fn(64'h8000_3000), 3'd5, 2'd3, 0), a, 64'h8000_0114);
        issue(b, o, 1, r);
        n = 0;
        do begin @(negedge clk); n++; end while (!ms_to_ws_valid && n < 50);
        check("bp_reached_done", ms_to_ws_valid, 1);
        repeat (2) @(negedge clk);
        bp_mode = 1;
        @(posedge clk); #1;
        a = 64'h8000_4008;
        r = '{addr: a, wen: 0, wdata: '0, wmask: '0};
        b = mk_in(32'h0003_B503, 1, 5'd10, 2'd1, 1, 0, 2'd2, 0, 64'd0, a, 64'h8000_0118);
        o = mk_out(32'h0003_B503, 1, 5'd10, 2'd1, load_model(mem_fn(a), 3'd0, 2'd2, 0), a, 64'h8000_0118);
        issue(b, o, 1, r);
        @(negedge clk);
        check("done_to_req", data_req_valid, 1);
        wait_empty(50);

        // reset while waiting for a response
        rsp_hold = 1;
        a = 64'h8000_5000;
        r = '{addr: a, wen: 0, wdata: '0, wmask: '0};
        b = mk_in(32'h0004_B583, 1, 5'd11, 2'd1, 1, 0, 2'd3, 0, 64'd0, a, 64'h8000_011C);
        o = mk_out(32'h0004_B583, 1, 5'd11, 2'd1, mem_fn(a), a, 64'h8000_011C);
        issue(b, o, 1, r);
        repeat (2) @(negedge clk);
        check("wait_req_low", data_req_valid, 0);
        check("wait_allowin", ms_allowin, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_req_valid", data_req_valid, 0);
        check("midrst_wb_valid", ms_to_ws_valid, 0);
        check("midrst_allowin", ms_allowin, 1);
        sb_q.delete();
        rq_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rsp_hold = 0;
        inject_spur = 1;
        @(negedge clk);
        inject_spur = 0;
        repeat (3) begin
            @(negedge clk);
            check("late_resp_wb", ms_to_ws_valid, 0);
            check("late_resp_allowin", ms_allowin, 1);
            check("late_resp_req", data_req_valid, 0);
        end
        @(posedge clk); #1;

        // random traffic
        bp_mode = 0; ready_mode = 2; rsp_max = 3; spur_en = 1;
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            inst = $urandom; rw = 1'($urandom); rd = 5'($urandom); sel = 2'($urandom);
            sz = 2'($urandom); uns = 1'($urandom);
            sd = {$urandom, $urandom}; a = {$urandom, $urandom}; pc = {$urandom, $urandom};
            r = none;
            rdv = 64'd0;
            if (kind == 1) begin
                rdv = load_model(mem_fn({a[63:3], 3'b000}), a[2:0], sz, uns);
                r = '{addr: {a[63:3], 3'b000}, wen: 0, wdata: '0, wmask: '0};
            end else if (kind == 2) begin
                r = '{addr: {a[63:3], 3'b000}, wen: 1,
                      wdata: sd << (8 * a[2:0]), wmask: store_mask(a[2:0], sz)};
            end
            b = mk_in(inst, rw, rd, sel, kind == 1, kind == 2, sz, uns, sd, a, pc);
            o = mk_out(inst, rw, rd, sel, rdv, a, pc);
            issue(b, o, kind != 0, r);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        bp_mode = 1; ready_mode = 1; spur_en = 0;
        wait_empty(1000);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
